// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the program counter, drives the
// instruction memory's address/flush/stall, and produces pc_id/valid_id
// aligned with the memory's registered instruction output.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        halt_req,
    input  logic        resume_req,
    output logic [31:0] pc,
    output logic        imem_flush,
    output logic        imem_stall,
    output logic [31:0] pc_id,
    output logic        valid_id,
    output logic        misalign_exc,
    output logic [31:0] misalign_addr
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_id_q;
    logic        valid_id_q;
    logic        misalign_exc_q;
    logic [31:0] misalign_addr_q;

    logic [31:0] trap_entry;
    logic        redirect_aligned;

    // The trap handler is always word aligned; low vector bits are dropped.
    assign trap_entry       = {trap_vec[31:2], 2'b00};
    assign redirect_aligned = (redirect_target[1:0] == 2'b00);

    // Flush overrides any stall; stall covers back-pressure, a halt request
    // being accepted this cycle, and the whole halted period.
    always_comb begin
        imem_flush = trap_req | redirect_valid;
        imem_stall = ~imem_flush &
                     (stall_in | (state_q == ST_RUN && halt_req) | (state_q == ST_HALT));
    end

    // Next-PC arbitration and run/halt FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RUN;
            pc_q            <= RESET_PC;
            pc_id_q         <= 32'h0000_0000;
            valid_id_q      <= 1'b0;
            misalign_exc_q  <= 1'b0;
            misalign_addr_q <= 32'h0000_0000;
        end else begin
            // The misalignment flag is a single-cycle pulse.
            misalign_exc_q <= 1'b0;
            if (trap_req) begin
                pc_q       <= trap_entry;
                pc_id_q    <= 32'h0000_0000;
                valid_id_q <= 1'b0;
                state_q    <= ST_RUN;
            end else if (redirect_valid && redirect_aligned) begin
                pc_q       <= redirect_target;
                pc_id_q    <= 32'h0000_0000;
                valid_id_q <= 1'b0;
                state_q    <= ST_RUN;
            end else if (redirect_valid) begin
                // Misaligned target: branch not taken, enter the trap handler.
                pc_q            <= trap_entry;
                pc_id_q         <= 32'h0000_0000;
                valid_id_q      <= 1'b0;
                misalign_exc_q  <= 1'b1;
                misalign_addr_q <= redirect_target;
                state_q         <= ST_RUN;
            end else if (state_q == ST_HALT) begin
                // pc holds on the resume edge; fetch restarts on the next one.
                valid_id_q <= 1'b0;
                if (resume_req) begin
                    state_q <= ST_RUN;
                end
            end else if (halt_req) begin
                valid_id_q <= 1'b0;
                state_q    <= ST_HALT;
            end else if (stall_in) begin
                // Everything holds while decode back-pressures.
                pc_q <= pc_q;
            end else begin
                pc_q       <= pc_q + PC_STEP;
                pc_id_q    <= pc_q;
                valid_id_q <= 1'b1;
            end
        end
    end

    assign pc            = pc_q;
    assign pc_id         = pc_id_q;
    assign valid_id      = valid_id_q;
    assign misalign_exc  = misalign_exc_q;
    assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic        halt_req;
    logic        resume_req;
    logic [31:0] pc;
    logic        imem_flush;
    logic        imem_stall;
    logic [31:0] pc_id;
    logic        valid_id;
    logic        misalign_exc;
    logic [31:0] misalign_addr;

    int n_checks = 0;
    int n_errors = 0;

    fetch_pc_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_req       (trap_req),
        .trap_vec       (trap_vec),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .pc             (pc),
        .imem_flush     (imem_flush),
        .imem_stall     (imem_stall),
        .pc_id          (pc_id),
        .valid_id       (valid_id),
        .misalign_exc   (misalign_exc),
        .misalign_addr  (misalign_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_id, input logic e_valid);
        check_eq({tag, ".pc"}, pc, e_pc);
        check_eq({tag, ".pc_id"}, pc_id, e_id);
        check_eq({tag, ".valid_id"}, {31'd0, valid_id}, {31'd0, e_valid});
    endtask

    task automatic clear_inputs();
        stall_in        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap_req        = 1'b0;
        trap_vec        = 32'h0;
        halt_req        = 1'b0;
        resume_req      = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #3;
        check_fetch("reset", 32'h0, 32'h0, 1'b0);
        check_eq("reset.misalign_exc", {31'd0, misalign_exc}, 32'd0);
        check_eq("reset.misalign_addr", misalign_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch
        tick(); check_fetch("seq1", 32'h4, 32'h0, 1'b1);
        tick(); check_fetch("seq2", 32'h8, 32'h4, 1'b1);
        tick(); check_fetch("seq3", 32'hC, 32'h8, 1'b1);
        tick(); check_fetch("seq4", 32'h10, 32'hC, 1'b1);

        // resume_req in RUN is ignored
        resume_req = 1'b1;
        tick(); check_fetch("resume_in_run", 32'h14, 32'h10, 1'b1);
        resume_req = 1'b0;

        // Aligned redirect
        redirect_valid = 1'b1; redirect_target = 32'h200;
        #1;
        check_eq("redir.flush", {31'd0, imem_flush}, 32'd1);
        check_eq("redir.stall", {31'd0, imem_stall}, 32'd0);
        tick(); check_fetch("redir.edge", 32'h200, 32'h0, 1'b0);
        redirect_valid = 1'b0;
        tick(); check_fetch("redir.next", 32'h204, 32'h200, 1'b1);

        // Stall for 3 cycles, then redirect overrides stall
        stall_in = 1'b1;
        #1;
        check_eq("stall.imem_stall", {31'd0, imem_stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); check_fetch("stall.hold", 32'h204, 32'h200, 1'b1);
        end
        redirect_valid = 1'b1; redirect_target = 32'h40;
        #1;
        check_eq("stallredir.flush", {31'd0, imem_flush}, 32'd1);
        check_eq("stallredir.stall", {31'd0, imem_stall}, 32'd0);
        tick(); check_fetch("stallredir.edge", 32'h40, 32'h0, 1'b0);
        redirect_valid = 1'b0; stall_in = 1'b0;

        // Misaligned redirect goes to the trap vector
        redirect_valid = 1'b1; redirect_target = 32'h102; trap_vec = 32'h81;
        #1;
        check_eq("misal.flush", {31'd0, imem_flush}, 32'd1);
        tick();
        check_fetch("misal.edge", 32'h80, 32'h0, 1'b0);
        check_eq("misal.exc", {31'd0, misalign_exc}, 32'd1);
        check_eq("misal.addr", misalign_addr, 32'h102);
        redirect_valid = 1'b0;
        tick();
        check_eq("misal.exc_pulse", {31'd0, misalign_exc}, 32'd0);
        check_eq("misal.addr_held", misalign_addr, 32'h102);
        check_fetch("misal.next", 32'h84, 32'h80, 1'b1);

        // Halt at pc=0x8, stay halted, resume (with halt_req also high)
        redirect_valid = 1'b1; redirect_target = 32'h8;
        tick(); check_fetch("halt.setup", 32'h8, 32'h0, 1'b0);
        redirect_valid = 1'b0;
        halt_req = 1'b1;
        #1;
        check_eq("halt.req_stall", {31'd0, imem_stall}, 32'd1);
        tick(); check_fetch("halt.enter", 32'h8, 32'h0, 1'b0);
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("halt.imem_stall", {31'd0, imem_stall}, 32'd1);
            tick(); check_fetch("halt.hold", 32'h8, 32'h0, 1'b0);
        end
        halt_req = 1'b1; resume_req = 1'b1;
        tick(); check_fetch("resume.edge", 32'h8, 32'h0, 1'b0);
        halt_req = 1'b0; resume_req = 1'b0;
        #1;
        check_eq("resume.no_stall", {31'd0, imem_stall}, 32'd0);
        tick(); check_fetch("resume.next", 32'hC, 32'h8, 1'b1);

        // Trap beats redirect (aligned and misaligned targets)
        trap_req = 1'b1; trap_vec = 32'h100; redirect_valid = 1'b1; redirect_target = 32'h300;
        tick();
        check_fetch("trapredir", 32'h100, 32'h0, 1'b0);
        check_eq("trapredir.exc", {31'd0, misalign_exc}, 32'd0);
        trap_vec = 32'h203; redirect_target = 32'h302;
        tick();
        check_eq("trapmisal.pc", pc, 32'h200);
        check_eq("trapmisal.exc", {31'd0, misalign_exc}, 32'd0);
        check_eq("trapmisal.addr", misalign_addr, 32'h102);
        trap_req = 1'b0; redirect_valid = 1'b0;

        // PC wrap
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick(); check_fetch("wrap.setup", 32'hFFFF_FFFC, 32'h0, 1'b0);
        redirect_valid = 1'b0;
        tick(); check_fetch("wrap.edge", 32'h0, 32'hFFFF_FFFC, 1'b1);

        // Redirect while halted wakes the block
        halt_req = 1'b1;
        tick(); check_fetch("hredir.halt", 32'h0, 32'hFFFF_FFFC, 1'b0);
        halt_req = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h500;
        tick(); check_fetch("hredir.edge", 32'h500, 32'h0, 1'b0);
        redirect_valid = 1'b0;
        tick(); check_fetch("hredir.next", 32'h504, 32'h500, 1'b1);

        // Asynchronous reset mid-stall
        stall_in = 1'b1;
        tick(); check_fetch("rststall.hold", 32'h504, 32'h500, 1'b1);
        rst = 1'b1;
        #1;
        check_fetch("rststall.async", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0; stall_in = 1'b0;
        tick(); check_fetch("rststall.first", 32'h4, 32'h0, 1'b1);

        // Asynchronous reset mid-halt
        halt_req = 1'b1;
        tick(); check_fetch("rsthalt.halt", 32'h4, 32'h0, 1'b0);
        halt_req = 1'b0;
        rst = 1'b1;
        #1;
        check_fetch("rsthalt.async", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(); check_fetch("rsthalt.first", 32'h4, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
